// File: rtl/vproc_pkg.sv
// Shared types for the vector processor's x-register result path.
// Holds the reorder-buffer entry state enum and the x-register payload widths.
package vproc_pkg;

    localparam int unsigned XREG_ADDR_W = 5;
    localparam int unsigned XREG_DATA_W = 32;

    // Lifecycle of one x-register ROB entry.
    typedef enum logic [1:0] {
        ROB_FREE    = 2'd0,
        ROB_PENDING = 2'd1,
        ROB_DONE    = 2'd2
    } rob_state_e;

endpackage

// File: rtl/vproc_xreg_rob_if.sv
// Bundle of the x-register ROB handshakes: allocation, writeback and result.
// master = the side that issues/writes back/consumes (pipeline + result stage),
// slave  = the ROB itself.
interface vproc_xreg_rob_if
    import vproc_pkg::*;
#(
    parameter int unsigned XIF_ID_W = 3
) ();

    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [XIF_ID_W-1:0]    alloc_id;

    logic                   wb_valid;
    logic [XIF_ID_W-1:0]    wb_id;
    logic [XREG_ADDR_W-1:0] wb_addr;
    logic [XREG_DATA_W-1:0] wb_data;

    logic                   result_valid;
    logic                   result_ready;
    logic [XIF_ID_W-1:0]    result_id;
    logic [XREG_ADDR_W-1:0] result_addr;
    logic [XREG_DATA_W-1:0] result_data;

    modport master (
        output alloc_valid, alloc_id,
        output wb_valid, wb_id, wb_addr, wb_data,
        output result_ready,
        input  alloc_ready,
        input  result_valid, result_id, result_addr, result_data
    );

    modport slave (
        input  alloc_valid, alloc_id,
        input  wb_valid, wb_id, wb_addr, wb_data,
        input  result_ready,
        output alloc_ready,
        output result_valid, result_id, result_addr, result_data
    );

endinterface

// File: rtl/vproc_xreg_rob_sva.svh
// Protocol checks for vproc_xreg_rob, included inside the module body.
// Flags orphan writebacks, duplicate in-flight ids and unstable result offers.

logic [ROB_DEPTH-1:0] sva_alloc_dup;

// Entries already in flight that carry the id being allocated.
always_comb begin
    sva_alloc_dup = '0;
    for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        sva_alloc_dup[IDX_W'(i)] = (state_q[IDX_W'(i)] != ROB_FREE)
                                 && (id_q[IDX_W'(i)] == alloc_id_i);
    end
end

a_wb_hits_pending: assert property (
    @(posedge clk_i) disable iff (async_rst_i)
    wb_valid_i |-> (|wb_match)
);

a_alloc_id_unique: assert property (
    @(posedge clk_i) disable iff (async_rst_i)
    alloc_fire |-> !(|sva_alloc_dup)
);

a_result_stable: assert property (
    @(posedge clk_i) disable iff (async_rst_i)
    (result_xreg_valid_o && !result_xreg_ready_i) |=>
        (result_xreg_valid_o
         && $stable(result_xreg_id_o)
         && $stable(result_xreg_addr_o)
         && $stable(result_xreg_data_o))
);

// File: rtl/vproc_xreg_rob.sv
// Reorder buffer for x-register results: instructions allocate in issue order,
// pipelines write back out of order, results leave strictly in allocation order.
// Ports:
//   clk_i, async_rst_i            clock, asynchronous active-high reset
//   alloc_valid_i/ready_o/id_i    allocation of an entry for an issued instruction
//   wb_valid_i/id_i/addr_i/data_i writeback of a finished result (no backpressure)
//   result_xreg_valid_o/ready_i   head-entry result handshake
//   result_xreg_id/addr/data_o    head-entry payload
module vproc_xreg_rob
    import vproc_pkg::*;
#(
    parameter int unsigned XIF_ID_W       = 3,
    parameter int unsigned ROB_DEPTH      = 4,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   async_rst_i,

    input  logic                   alloc_valid_i,
    output logic                   alloc_ready_o,
    input  logic [XIF_ID_W-1:0]    alloc_id_i,

    input  logic                   wb_valid_i,
    input  logic [XIF_ID_W-1:0]    wb_id_i,
    input  logic [XREG_ADDR_W-1:0] wb_addr_i,
    input  logic [XREG_DATA_W-1:0] wb_data_i,

    output logic                   result_xreg_valid_o,
    input  logic                   result_xreg_ready_i,
    output logic [XIF_ID_W-1:0]    result_xreg_id_o,
    output logic [XREG_ADDR_W-1:0] result_xreg_addr_o,
    output logic [XREG_DATA_W-1:0] result_xreg_data_o
);

    localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    rob_state_e             state_q [ROB_DEPTH];
    rob_state_e             state_d [ROB_DEPTH];
    logic [XIF_ID_W-1:0]    id_q    [ROB_DEPTH];
    logic [XREG_ADDR_W-1:0] addr_q  [ROB_DEPTH];
    logic [XREG_DATA_W-1:0] data_q  [ROB_DEPTH];

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [IDX_W-1:0]       head_idx, tail_idx;
    logic                   full;
    logic                   alloc_fire;
    logic                   retire_fire;
    logic [ROB_DEPTH-1:0]   wb_match;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign full          = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
    assign alloc_ready_o = ~full;
    assign alloc_fire    = alloc_valid_i & ~full;

    assign result_xreg_valid_o = (state_q[head_idx] == ROB_DONE);
    assign retire_fire         = result_xreg_valid_o & result_xreg_ready_i;

    // Id-match CAM; only PENDING entries can match, so the entry being
    // allocated this cycle (still FREE) and DONE entries are never hit.
    always_comb begin
        wb_match = '0;
        for (int i = 0; i < int'(ROB_DEPTH); i++) begin
            wb_match[IDX_W'(i)] = wb_valid_i
                                && (state_q[IDX_W'(i)] == ROB_PENDING)
                                && (id_q[IDX_W'(i)] == wb_id_i);
        end
    end

    // Next entry states and pointers. Writeback, retire and allocate always
    // touch distinct entries (PENDING, DONE head, FREE tail respectively).
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        for (int i = 0; i < int'(ROB_DEPTH); i++) begin
            if (wb_match[IDX_W'(i)]) begin
                state_d[IDX_W'(i)] = ROB_DONE;
            end
        end
        if (retire_fire) begin
            state_d[head_idx] = ROB_FREE;
            head_d            = head_q + PTR_W'(1);
        end
        if (alloc_fire) begin
            state_d[tail_idx] = ROB_PENDING;
            tail_d            = tail_q + PTR_W'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                state_q[IDX_W'(i)] <= ROB_FREE;
            end
            head_q <= '0;
            tail_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Entry payload storage; meaningless while FREE, so left unreset.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            id_q[tail_idx] <= alloc_id_i;
        end
        for (int i = 0; i < int'(ROB_DEPTH); i++) begin
            if (wb_match[IDX_W'(i)]) begin
                addr_q[IDX_W'(i)] <= wb_addr_i;
                data_q[IDX_W'(i)] <= wb_data_i;
            end
        end
    end

    // Head payload, don't-care while no result is offered.
    always_comb begin
        result_xreg_id_o   = DONT_CARE_ZERO ? '0 : 'x;
        result_xreg_addr_o = DONT_CARE_ZERO ? '0 : 'x;
        result_xreg_data_o = DONT_CARE_ZERO ? '0 : 'x;
        if (result_xreg_valid_o) begin
            result_xreg_id_o   = id_q[head_idx];
            result_xreg_addr_o = addr_q[head_idx];
            result_xreg_data_o = data_q[head_idx];
        end
    end

`ifdef VPROC_SVA
`include "vproc_xreg_rob_sva.svh"
`endif

endmodule

// File: tb/tb_vproc_xreg_rob.sv
// Bench for vproc_xreg_rob: directed scenarios plus randomized traffic, all
// checked every cycle against an in-order queue model of the ROB.
module tb_vproc_xreg_rob;
    import vproc_pkg::*;

    localparam int unsigned ID_W  = 3;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vproc_xreg_rob_if #(.XIF_ID_W(ID_W)) bus ();

    vproc_xreg_rob #(
        .XIF_ID_W       (ID_W),
        .ROB_DEPTH      (DEPTH),
        .DONT_CARE_ZERO (1'b0)
    ) dut (
        .clk_i               (clk),
        .async_rst_i         (rst),
        .alloc_valid_i       (bus.alloc_valid),
        .alloc_ready_o       (bus.alloc_ready),
        .alloc_id_i          (bus.alloc_id),
        .wb_valid_i          (bus.wb_valid),
        .wb_id_i             (bus.wb_id),
        .wb_addr_i           (bus.wb_addr),
        .wb_data_i           (bus.wb_data),
        .result_xreg_valid_o (bus.result_valid),
        .result_xreg_ready_i (bus.result_ready),
        .result_xreg_id_o    (bus.result_id),
        .result_xreg_addr_o  (bus.result_addr),
        .result_xreg_data_o  (bus.result_data)
    );

    // Reference model: in-flight instructions in allocation order.
    typedef struct {
        logic [ID_W-1:0] id;
        bit              done;
        logic [4:0]      addr;
        logic [31:0]     data;
    } ent_t;

    ent_t mq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit in_flight(input int id);
        foreach (mq[k]) if (int'(mq[k].id) == id) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the model, using the inputs that were presented to it.
    function automatic void model_step();
        bit   can_alloc = (mq.size() < int'(DEPTH));
        bit   retire    = (mq.size() > 0) && mq[0].done && (bus.result_ready === 1'b1);
        ent_t e;
        if (bus.wb_valid === 1'b1) begin
            foreach (mq[k]) begin
                if (!mq[k].done && mq[k].id == bus.wb_id) begin
                    mq[k].done = 1'b1;
                    mq[k].addr = bus.wb_addr;
                    mq[k].data = bus.wb_data;
                end
            end
        end
        if (retire) void'(mq.pop_front());
        if ((bus.alloc_valid === 1'b1) && can_alloc) begin
            e.id   = bus.alloc_id;
            e.done = 1'b0;
            e.addr = '0;
            e.data = '0;
            mq.push_back(e);
        end
    endfunction

    always @(posedge rst) mq.delete();

    // Monitor: just after each edge, advance the model and compare outputs.
    initial begin
        bit exp_valid;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) model_step();
            exp_valid = (mq.size() > 0) && mq[0].done;
            chk("alloc_ready", 32'(bus.alloc_ready), 32'(mq.size() < int'(DEPTH)));
            chk("result_valid", 32'(bus.result_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("result_id",   32'(bus.result_id),   32'(mq[0].id));
                chk("result_addr", 32'(bus.result_addr), 32'(mq[0].addr));
                chk("result_data", bus.result_data,      mq[0].data);
            end
        end
    end

    task automatic apply(input bit av, input int aid, input bit wv, input int wid,
                         input int waddr, input logic [31:0] wdata, input bit rdy);
        bus.alloc_valid  = av;
        bus.alloc_id     = ID_W'(aid);
        bus.wb_valid     = wv;
        bus.wb_id        = ID_W'(wid);
        bus.wb_addr      = 5'(waddr);
        bus.wb_data      = wdata;
        bus.result_ready = rdy;
    endtask

    task automatic drive(input bit av, input int aid, input bit wv, input int wid,
                         input int waddr, input logic [31:0] wdata, input bit rdy);
        @(negedge clk);
        apply(av, aid, wv, wid, waddr, wdata, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) drive(1'b0, 0, 1'b0, 0, 0, 32'h0, rdy);
    endtask

    // Random legal cycle: fresh alloc id, writeback of a pending id, random ready.
    task automatic rand_cycle(input int p_alloc, input int p_wb, input int p_rdy);
        int pend[$];
        int aid, wid;
        bit av, wv, rdy;
        @(negedge clk);
        av = ($urandom_range(99) < 32'(p_alloc));
        do aid = int'($urandom_range((1 << ID_W) - 1)); while (in_flight(aid));
        foreach (mq[k]) if (!mq[k].done) pend.push_back(int'(mq[k].id));
        wv  = (pend.size() > 0) && ($urandom_range(99) < 32'(p_wb));
        wid = wv ? pend[$urandom_range(pend.size() - 1)] : 0;
        rdy = ($urandom_range(99) < 32'(p_rdy));
        apply(av, aid, wv, wid, int'($urandom_range(31)), $urandom, rdy);
    endtask

    // Write back the oldest pending entry each cycle with ready held high.
    task automatic drain(input int n);
        repeat (n) begin
            int  wid = 0;
            bit  wv  = 1'b0;
            @(negedge clk);
            foreach (mq[k]) if (!wv && !mq[k].done) begin wv = 1'b1; wid = int'(mq[k].id); end
            apply(1'b0, 0, wv, wid, int'($urandom_range(31)), $urandom, 1'b1);
        end
    endtask

    // Reset pulse entirely between two rising edges.
    task automatic reset_pulse();
        @(negedge clk);
        apply(1'b0, 0, 1'b0, 0, 0, 32'h0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_result_valid", 32'(bus.result_valid), 32'h0);
        chk("rst_alloc_ready",  32'(bus.alloc_ready),  32'h1);
        #1 rst = 1'b0;
    endtask

    initial begin
        apply(1'b0, 0, 1'b0, 0, 0, 32'h0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b1);

        // In order: ids 1,2 written back in order.
        drive(1'b1, 1, 1'b0, 0, 0, 32'h0, 1'b1);
        drive(1'b1, 2, 1'b0, 0, 0, 32'h0, 1'b1);
        drive(1'b0, 0, 1'b1, 1, 5, 32'hA5A5A5A5, 1'b1);
        drive(1'b0, 0, 1'b1, 2, 6, 32'h5A5A5A5A, 1'b1);
        idle(3, 1'b1);

        // Out of order: ids 3,4,5 written back 5,4,3.
        drive(1'b1, 3, 1'b0, 0, 0, 32'h0, 1'b1);
        drive(1'b1, 4, 1'b0, 0, 0, 32'h0, 1'b1);
        drive(1'b1, 5, 1'b0, 0, 0, 32'h0, 1'b1);
        drive(1'b0, 0, 1'b1, 5, 10, 32'h0000_0005, 1'b1);
        drive(1'b0, 0, 1'b1, 4, 11, 32'h0000_0004, 1'b1);
        drive(1'b0, 0, 1'b1, 3, 12, 32'h0000_0003, 1'b1);
        idle(4, 1'b1);

        // Full and wrap: fill, attempt an extra alloc, retire one.
        for (int i = 1; i <= 4; i++) drive(1'b1, i, 1'b0, 0, 0, 32'h0, 1'b0);
        drive(1'b1, 5, 1'b0, 0, 0, 32'h0, 1'b0);
        for (int i = 1; i <= 4; i++) drive(1'b0, 0, 1'b1, i, i, 32'h100 + 32'(i), 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        repeat (12) rand_cycle(90, 90, 90);
        drain(12);

        // Backpressure: head DONE held for 5 cycles.
        drive(1'b1, 7, 1'b0, 0, 0, 32'h0, 1'b0);
        drive(1'b0, 0, 1'b1, 7, 31, 32'hDEAD_BEEF, 1'b0);
        idle(5, 1'b0);
        idle(3, 1'b1);

        // Same-cycle alloc of 6, writeback of 4, retire of head 3.
        drive(1'b1, 3, 1'b0, 0, 0, 32'h0, 1'b0);
        drive(1'b1, 4, 1'b0, 0, 0, 32'h0, 1'b0);
        drive(1'b0, 0, 1'b1, 3, 3, 32'h3333_3333, 1'b0);
        drive(1'b1, 6, 1'b1, 4, 4, 32'h4444_4444, 1'b1);
        idle(2, 1'b1);
        drain(4);

        // Reset mid-operation with three pending entries.
        drive(1'b1, 1, 1'b0, 0, 0, 32'h0, 1'b1);
        drive(1'b1, 2, 1'b0, 0, 0, 32'h0, 1'b1);
        drive(1'b1, 3, 1'b0, 0, 0, 32'h0, 1'b1);
        reset_pulse();
        drive(1'b0, 0, 1'b1, 2, 9, 32'hBAD0_0002, 1'b1);
        idle(3, 1'b1);

        // Randomized traffic.
        repeat (400) rand_cycle(60, 50, 70);
        drain(20);
        idle(2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
